step_pulse_gen: RTL
===================

# step_pulse_gen

Step/direction pulse generator for the stepper-motor drive path. Sits directly downstream of the AUTO/MANUAL mode selector and consumes its `drv_en_TR`, `dir_TR`, `counter_en_TR` and `period_TR` outputs. Converts them into a timed STEP pulse train and a DIR line with guaranteed direction setup time. Also maintains a signed position counter and a gated step counter.

## Interface
- `WIDTH_TR`, default 16: width of `period_TR` and of the internal period/low-time counters.
- `PULSE_W`, default 4: STEP high time in clocks; must be ≥1.
- `DIR_SETUP`, default 2: clocks that DIR must be stable before a STEP rising edge after a direction change; must be ≥1.
- `POS_W`, default 32: width of `pos_cnt` and `step_cnt`.

Ports:
- `clk`  input  1  system clock; everything is on the rising edge.
- `rst`  input  1  reset, synchronous, active-low.
- `drv_en_TR`  input  1  stepping enable.
- `dir_TR`  input  1  requested direction; 1 = positive.
- `counter_en_TR`  input  1  step-count gate.
- `period_TR`  input  WIDTH_TR  STEP period in clocks, measured rising edge to rising edge.
- `step_out`  output  1  STEP pulse to the driver, registered.
- `dir_out`  output  1  DIR to the driver, registered.
- `busy`  output  1  high in any state except IDLE.
- `pos_cnt`  output  POS_W  signed position, two's complement.
- `step_cnt`  output  POS_W  unsigned count of gated steps.

## Operation
- FSM states: IDLE, SETUP, HIGH, LOW. A period is valid when `period_TR > PULSE_W`.
- IDLE:
  - `step_out`=0.
  - If `drv_en_TR`=1 and the period is valid: latch `period_TR` into `per_q`.
  - If `dir_TR`≠`dir_out`: load `dir_out`←`dir_TR` and go to SETUP. Otherwise go to HIGH.
  - With an invalid period the block stays in IDLE.
- SETUP:
  - Hold `step_out`=0 for DIR_SETUP cycles, then go to HIGH.
  - `dir_out` does not change in this state.
- HIGH:
  - `step_out`=1 for PULSE_W cycles, then go to LOW.
  - On the first HIGH cycle only:
    - `pos_cnt` increments by 1 if `dir_out`=1, otherwise decrements by 1. It wraps with no saturation.
    - If `counter_en_TR`=1, `step_cnt` increments and saturates at all-ones.
- LOW:
  - `step_out`=0 for `per_q`−PULSE_W cycles.
  - On the last LOW cycle the IDLE evaluation is reapplied: relatch the period and check direction, then go to SETUP or HIGH. If `drv_en_TR`=0 or the period is invalid, go to IDLE.
- `drv_en_TR`, `period_TR` and `dir_TR` are sampled only at period boundaries (IDLE or the last LOW cycle). Mid-period changes never truncate a pulse or its low time.
- A 0→1 transition on `counter_en_TR` (registered edge detect) clears `step_cnt` to 0 in that cycle. If a step occurs in the same cycle, the result is 1.
- While `counter_en_TR`=0, `step_cnt` holds its value.
- Reset (`rst`=0 at an edge), at any point including mid-pulse:
  - State goes to IDLE.
  - `step_out`=0, `dir_out`=0, `busy`=0, `pos_cnt`=0, `step_cnt`=0.
  - `per_q` and all internal counters are cleared.

## Timing
- `drv_en_TR` sampled high in IDLE at edge N, no direction change: `step_out`=1 and the `pos_cnt` update are visible after edge N+1.
- Same case with a direction change: `dir_out` updates after edge N+1, and `step_out` rises after edge N+1+DIR_SETUP.
- Steady state: successive STEP rising edges are exactly `per_q` clocks apart. High time is PULSE_W clocks; low time is `per_q`−PULSE_W clocks.
- A direction change between pulses inserts DIR_SETUP extra clocks between the affected rising edges.
- `busy` is registered with the state: high from N+1 until the edge after the last LOW cycle of the final period.

## Test plan
- Reset: hold `rst`=0 for 3 clocks with `drv_en_TR`=1 -> all outputs 0, no STEP edges.
- Steady run with PULSE_W=4, `period_TR`=10, `dir_TR`=0, `drv_en_TR`=1 -> first rising edge 1 clock after enable, 4 high / 6 low, rising edges 10 clocks apart. After 3 pulses `pos_cnt`=−3.
- Direction reversal: during run 2 set `dir_TR`=1 mid-HIGH -> the current period completes, `dir_out` rises, next rising edge arrives 2 clocks later (DIR_SETUP=2), `pos_cnt` goes −3→−2.
- Invalid period: `period_TR`=4 or 0 with `drv_en_TR`=1 -> `step_out` stays 0, `busy` stays 0, counters unchanged.
- Disable mid-pulse: drop `drv_en_TR` on the 2nd HIGH cycle -> pulse still 4 clocks high, 6 clocks low, then IDLE. `busy` falls 10 clocks after that rising edge.
- Step counting and reset mid-pulse:
  - Raise `counter_en_TR` -> `step_cnt` clears.
  - After 5 pulses `step_cnt`=5.
  - Lower `counter_en_TR` for 3 pulses -> `step_cnt` stays 5.
  - Assert `rst`=0 mid-HIGH -> `step_out`=0 and all counters 0 after that edge.

Source files
------------

// File: rtl/step_pulse_gen.sv
// rtl/step_pulse_gen.sv - step/direction pulse generator with position and gated step counters
// Outputs are registered one cycle behind the state register, so DIR, STEP and busy move together.
module step_pulse_gen #(
  parameter int WIDTH_TR  = 16,
  parameter int PULSE_W   = 4,
  parameter int DIR_SETUP = 2,
  parameter int POS_W     = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                drv_en_TR,
  input  logic                dir_TR,
  input  logic                counter_en_TR,
  input  logic [WIDTH_TR-1:0] period_TR,
  output logic                step_out,
  output logic                dir_out,
  output logic                busy,
  output logic [POS_W-1:0]    pos_cnt,
  output logic [POS_W-1:0]    step_cnt
);

  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

  localparam logic [WIDTH_TR-1:0] PW  = WIDTH_TR'(PULSE_W);
  localparam logic [WIDTH_TR-1:0] DS  = WIDTH_TR'(DIR_SETUP);
  localparam logic [WIDTH_TR-1:0] ONE = WIDTH_TR'(1);
  localparam logic [POS_W-1:0]    P1  = POS_W'(1);

  state_t              state, state_nx;
  logic [WIDTH_TR-1:0] per_q, per_nx, cnt, cnt_nx;
  logic                dir_q, dir_nx, cen_q;
  logic                go, boundary, first_high, cen_rise;

  always_comb begin
    state_nx = state;
    per_nx   = per_q;
    dir_nx   = dir_q;
    cnt_nx   = cnt + ONE;
    boundary = 1'b0;
    go       = drv_en_TR && (period_TR > PW);
    case (state)
      IDLE:  boundary = 1'b1;
      SETUP: if (cnt == DS - ONE) begin
               state_nx = HIGH;
               cnt_nx   = '0;
             end
      HIGH:  if (cnt == PW - ONE) begin
               state_nx = LOW;
               cnt_nx   = '0;
             end
      LOW:   if (cnt == per_q - PW - ONE) boundary = 1'b1;
      default: state_nx = IDLE;
    endcase
    // Inputs are only honoured at period boundaries so a pulse is never truncated.
    if (boundary) begin
      cnt_nx   = '0;
      state_nx = IDLE;
      if (go) begin
        per_nx = period_TR;
        if (dir_TR != dir_q) begin
          dir_nx   = dir_TR;
          state_nx = SETUP;
        end else begin
          state_nx = HIGH;
        end
      end
    end
  end

  assign first_high = (state == HIGH) && (cnt == '0);
  assign cen_rise   = counter_en_TR && !cen_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      per_q    <= '0;
      cnt      <= '0;
      dir_q    <= 1'b0;
      cen_q    <= 1'b0;
      step_out <= 1'b0;
      dir_out  <= 1'b0;
      busy     <= 1'b0;
      pos_cnt  <= '0;
      step_cnt <= '0;
    end else begin
      state    <= state_nx;
      per_q    <= per_nx;
      cnt      <= cnt_nx;
      dir_q    <= dir_nx;
      cen_q    <= counter_en_TR;
      step_out <= (state == HIGH);
      dir_out  <= dir_q;
      busy     <= (state != IDLE);
      if (first_high)
        pos_cnt <= dir_q ? pos_cnt + P1 : pos_cnt - P1;
      if (cen_rise)
        step_cnt <= first_high ? P1 : '0;
      else if (first_high && counter_en_TR && (step_cnt != '1))
        step_cnt <= step_cnt + P1;
    end
  end

endmodule
